actor_2_sink: RTL

Token sink for the Actor_2 output FIFO protocol, placed at the consumer end of the `source2_*` channel. It accepts up to `NTOK` 8-bit tokens, stores them in a small internal buffer and keeps a running sum and token count. It raises `full` when the firing budget is exhausted. An asynchronous read port exposes the captured tokens to downstream logic and to the bench.

---
 rtl/actor_2_sink.sv | 107 ++++++++++
 1 files changed

// File: rtl/actor_2_sink.sv
// actor_2_sink: consumer end of the Actor_2 source2 FIFO channel.
// Accepts up to NTOK tokens per run into a small buffer, tracking the running
// sum and token count, then holds in FULL until a restart pulse.
module actor_2_sink #(
  parameter int NTOK   = 5,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] sink_DATA,
  input  logic              sink_SEND,
  input  logic [15:0]       sink_COUNT,
  output logic              sink_ACK,
  output logic              sink_RDY,
  input  logic              restart,
  input  logic [2:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [31:0]       tok_cnt,
  output logic [15:0]       sum,
  output logic              full,
  output logic              err
);

  typedef enum logic [1:0] {
    ARM0,
    ARM1,
    RUN,
    FULL
  } state_t;

  localparam logic [31:0] NTOK_W = 32'(NTOK);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] buf_mem [8];
  logic              budget_left;
  logic              fire;

  // State register; reset parks the kicker in ARM0.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ARM0;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic plus the combinational handshake and status outputs.
  always_comb begin
    state_nxt   = state;
    budget_left = (tok_cnt < NTOK_W);
    fire        = 1'b0;
    sink_RDY    = 1'b0;
    full        = 1'b0;
    unique case (state)
      ARM0: state_nxt = ARM1;
      ARM1: state_nxt = RUN;
      RUN: begin
        sink_RDY = budget_left;
        fire     = sink_SEND && budget_left;
        if (fire && ((tok_cnt + 32'd1) == NTOK_W)) begin
          state_nxt = FULL;
        end
      end
      FULL: begin
        full = 1'b1;
        if (restart) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = ARM0;
    endcase
    sink_ACK = fire;
  end

  // Token capture, running sum/count, and the sticky no-count error.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tok_cnt <= '0;
      sum     <= '0;
      err     <= 1'b0;
      for (int unsigned k = 0; k < 8; k++) begin
        buf_mem[k] <= '0;
      end
    end else if (fire) begin
      buf_mem[tok_cnt[2:0]] <= sink_DATA;
      sum                   <= sum + 16'(sink_DATA);
      tok_cnt               <= tok_cnt + 32'd1;
      if (sink_COUNT == '0) begin
        err <= 1'b1;
      end
    end else if ((state == FULL) && restart) begin
      // Buffer contents and err survive a restart; only the run totals clear.
      tok_cnt <= '0;
      sum     <= '0;
    end
  end

  // Asynchronous read port; addresses beyond the run budget read as zero.
  always_comb begin
    rd_data = '0;
    if ({29'd0, rd_addr} < NTOK_W) begin
      rd_data = buf_mem[rd_addr];
    end
  end

endmodule
